// File: rtl/instr_fetcher_pkg.sv
// Shared constants and queue entry layout for the instruction fetcher.
// Fetch FSM encodings stay local to instr_fetcher.
package instr_fetcher_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t pred_pc;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction queue: one push and one pop per cycle, flush empties it.
// Head entry is presented combinationally; storage itself is never reset.
module instr_queue
  import instr_fetcher_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      en_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  iq_entry_t push_data_i,
  input  logic      pop_i,
  output iq_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             active;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[head_q];

  // A flush wins over any same-cycle push or pop.
  assign active  = en_i & ~flush_i;
  assign do_pop  = active & pop_i & ~empty_o;
  assign do_push = active & push_i & (~full_o | do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (en_i && flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetcher.sv
// Fetch front end: one outstanding ICache request, predictor-driven next PC,
// ROB redirect handling and an instruction queue feeding decode.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              IQ_DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rdy_i,
  output logic            ic_req_valid_o,
  output logic [XLEN-1:0] ic_req_pc_o,
  input  logic            ic_rsp_valid_i,
  input  logic [XLEN-1:0] ic_rsp_instr_i,
  output logic [XLEN-1:0] bp_pc_o,
  output logic [XLEN-1:0] bp_instr_o,
  input  logic [XLEN-1:0] bp_next_pc_i,
  output logic            iq_valid_o,
  output logic [XLEN-1:0] iq_instr_o,
  output logic [XLEN-1:0] iq_pc_o,
  output logic [XLEN-1:0] iq_pred_pc_o,
  input  logic            iq_pop_i,
  input  logic            rob_flush_i,
  input  logic [XLEN-1:0] rob_flush_pc_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            iq_full;
  logic            iq_empty;
  logic            iq_push;
  iq_entry_t       push_entry;
  iq_entry_t       head_entry;

  // Checking for space at request time guarantees room when the response lands.
  assign ic_req_valid_o = ~reset_i & rdy_i & ~rob_flush_i & (state_q == S_IDLE) & ~iq_full;
  assign ic_req_pc_o    = pc_q;

  assign bp_pc_o    = pc_q;
  assign bp_instr_o = ic_rsp_instr_i;

  assign iq_push    = rdy_i & ~rob_flush_i & (state_q == S_WAIT) & ic_rsp_valid_i;
  assign push_entry = '{pc: pc_q, instr: ic_rsp_instr_i, pred_pc: bp_next_pc_i};

  instr_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (rdy_i),
    .flush_i    (rob_flush_i),
    .push_i     (iq_push),
    .push_data_i(push_entry),
    .pop_i      (iq_pop_i),
    .head_o     (head_entry),
    .empty_o    (iq_empty),
    .full_o     (iq_full)
  );

  assign iq_valid_o   = ~reset_i & ~iq_empty;
  assign iq_instr_o   = head_entry.instr;
  assign iq_pc_o      = head_entry.pc;
  assign iq_pred_pc_o = head_entry.pred_pc;

  // A redirect with a request still in flight must swallow that stale response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (rdy_i) begin
      if (rob_flush_i) begin
        pc_d = rob_flush_pc_i;
        if (state_q != S_IDLE && !ic_rsp_valid_i) state_d = S_DISCARD;
        else                                      state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ic_req_valid_o) state_d = S_WAIT;
          end
          S_WAIT: begin
            if (ic_rsp_valid_i) begin
              pc_d    = bp_next_pc_i;
              state_d = S_IDLE;
            end
          end
          S_DISCARD: begin
            if (ic_rsp_valid_i) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: a small ICache/predictor model feeds the
// DUT and expected queue entries are compared as they reach the queue head.
module tb_instr_fetcher;
  import instr_fetcher_pkg::*;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy;
  logic        icReqValid;
  logic [31:0] icReqPc;
  logic        icRspValid;
  logic [31:0] icRspInstr;
  logic [31:0] bpPc;
  logic [31:0] bpInstr;
  logic [31:0] bpNextPc;
  logic        iqValid;
  logic [31:0] iqInstr;
  logic [31:0] iqPc;
  logic [31:0] iqPredPc;
  logic        iqPop;
  logic        robFlush;
  logic [31:0] robFlushPc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred;
  } exp_t;

  typedef enum {M_IDLE, M_WAIT, M_DISC} mstate_e;

  exp_t        sbQ[$];
  mstate_e     mState;
  logic [31:0] modelPc;
  int          rspDelay  = 1;
  int          countdown = 0;
  int          checks    = 0;
  int          failures  = 0;

  always #5 clk = ~clk;

  // Predictor model: always falls through to the next word.
  assign bpNextPc = bpPc + 32'd4;

  instr_fetcher #(
    .RESET_PC(RST_PC),
    .IQ_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .rdy_i         (rdy),
    .ic_req_valid_o(icReqValid),
    .ic_req_pc_o   (icReqPc),
    .ic_rsp_valid_i(icRspValid),
    .ic_rsp_instr_i(icRspInstr),
    .bp_pc_o       (bpPc),
    .bp_instr_o    (bpInstr),
    .bp_next_pc_i  (bpNextPc),
    .iq_valid_o    (iqValid),
    .iq_instr_o    (iqInstr),
    .iq_pc_o       (iqPc),
    .iq_pred_pc_o  (iqPredPc),
    .iq_pop_i      (iqPop),
    .rob_flush_i   (robFlush),
    .rob_flush_pc_i(robFlushPc)
  );

  function automatic logic [31:0] instrFor(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic resetDut(input logic r);
    @(negedge clk);
    reset      = 1'b1;
    rdy        = r;
    iqPop      = 1'b1;
    robFlush   = 1'b1;
    robFlushPc = 32'hDEAD_0000;
    icRspValid = 1'b1;
    #1;
    checkOutput("rst_req_valid", icReqValid, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid2", icReqValid, 1'b0);
    checkOutput("rst_iq_valid", iqValid, 1'b0);
    sbQ.delete();
    mState    = M_IDLE;
    modelPc   = RST_PC;
    countdown = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic applyStimulus(input logic r, input logic pop, input logic fl,
                               input logic [31:0] flPc, input logic forceRsp);
    logic rsp;
    logic expReq;
    exp_t h;
    @(negedge clk);
    rsp = forceRsp;
    if (r && countdown > 0) begin
      countdown--;
      if (countdown == 0) rsp = 1'b1;
    end
    reset      = 1'b0;
    rdy        = r;
    iqPop      = pop;
    robFlush   = fl;
    robFlushPc = flPc;
    icRspValid = rsp;
    icRspInstr = instrFor(modelPc);
    #1;
    expReq = r && !fl && (mState == M_IDLE) && (sbQ.size() < DEPTH);
    checkOutput("req_valid", icReqValid, expReq);
    if (expReq) checkOutput("req_pc", icReqPc, modelPc);
    checkOutput("iq_valid", iqValid, sbQ.size() != 0);
    if (sbQ.size() != 0) begin
      h = sbQ[0];
      checkOutput("iq_pc", iqPc, h.pc);
      checkOutput("iq_instr", iqInstr, h.instr);
      checkOutput("iq_pred_pc", iqPredPc, h.pred);
    end
    if (mState == M_WAIT) begin
      checkOutput("bp_pc", bpPc, modelPc);
      checkOutput("bp_instr", bpInstr, icRspInstr);
    end
    if (r) begin
      if (fl) begin
        sbQ.delete();
        modelPc = flPc;
        if (mState != M_IDLE && !rsp) mState = M_DISC;
        else                          mState = M_IDLE;
      end else begin
        if (pop && sbQ.size() != 0) h = sbQ.pop_front();
        if (rsp && mState == M_WAIT) begin
          h.pc    = modelPc;
          h.instr = instrFor(modelPc);
          h.pred  = modelPc + 32'd4;
          sbQ.push_back(h);
          modelPc = modelPc + 32'd4;
          mState  = M_IDLE;
        end else if (rsp && mState == M_DISC) begin
          mState = M_IDLE;
        end
        if (expReq) begin
          mState    = M_WAIT;
          countdown = rspDelay;
        end
      end
    end
  endtask

  initial begin
    logic fired;
    logic r;
    reset      = 1'b1;
    rdy        = 1'b1;
    iqPop      = 1'b0;
    robFlush   = 1'b0;
    robFlushPc = '0;
    icRspValid = 1'b0;
    icRspInstr = '0;
    mState     = M_IDLE;
    modelPc    = RST_PC;

    resetDut(1'b1);

    // Stream without pops until the queue fills and requests stop.
    rspDelay = 1;
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Random pops around full: exercises simultaneous push/pop and pointer wrap.
    repeat (80) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);

    // Redirect while a slow response is still outstanding.
    rspDelay = 3;
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    fired = 1'b0;
    for (int i = 0; i < 50 && !fired; i++) begin
      if (mState == M_WAIT && countdown == 3) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        fired = 1'b1;
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      end
    end
    checkOutput("flush_fired", fired, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Pause: every input pulse must be ignored while rdy is low.
    rspDelay = 1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'(i % 2), 1'(i == 2), 32'h200, 1'(i != 1));
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Mixed random traffic including pauses and redirects in every state.
    repeat (300) begin
      rspDelay = $urandom_range(1, 3);
      r = ($urandom_range(0, 7) != 0);
      applyStimulus(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                    32'($urandom_range(0, 255)) << 2, !r && ($urandom_range(0, 1) == 1));
    end

    // Reset must override a paused fetcher.
    resetDut(1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetcher.md
INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, PC loaded on reset.
REQ-002 SHALL have parameter IQ_DEPTH, default 16, instruction-queue entries, power of two, >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rdy  input  1  global enable; low = pause.
REQ-006 ic_req_valid  output  1  single-cycle fetch request to ICache.
REQ-007 ic_req_pc  output  32  address of the fetch request.
REQ-008 ic_rsp_valid  input  1  ICache returns the instruction for the outstanding request.
REQ-009 ic_rsp_instr  input  32  returned instruction word.
REQ-010 bp_pc  output  32  PC of the returned instruction, to predictor.
REQ-011 bp_instr  output  32  returned instruction, to predictor (equals ic_rsp_instr).
REQ-012 bp_next_pc  input  32  predicted next PC, combinational from predictor, same cycle.
REQ-013 iq_valid  output  1  queue head is valid (count != 0).
REQ-014 iq_instr / iq_pc / iq_pred_pc  output  32 each  head entry fields.
REQ-015 iq_pop  input  1  decoder consumes head this cycle.
REQ-016 rob_flush  input  1  misprediction redirect from ROB.
REQ-017 rob_flush_pc  input  32  correct PC on redirect.

Function
REQ-018 SHALL hold PC register, state in {IDLE, WAIT, DISCARD}, circular queue of {pc, instr, pred_pc} with head, tail, count.
REQ-019 IDLE: ic_req_valid = rdy & ~rob_flush & (count < IQ_DEPTH); ic_req_pc = PC; when asserted, next state WAIT.
REQ-020 WAIT: bp_pc = PC; on ic_rsp_valid push {PC, ic_rsp_instr, bp_next_pc} at tail, PC <= bp_next_pc, next state IDLE.
REQ-021 At most one outstanding request; the count < IQ_DEPTH check at request time guarantees space at response.
REQ-022 Earliest re-request is the cycle after a response (throughput at most 1 instr / 2 cycles + ICache latency).
REQ-023 Pop when iq_pop & count != 0: head advances, mod IQ_DEPTH; pop on empty queue ignored.
REQ-024 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-025 head/tail wrap from IQ_DEPTH-1 to 0; count width log2(IQ_DEPTH)+1.
REQ-026 rob_flush has highest priority: queue emptied (head=tail=count=0), any same-cycle push and pop dropped, PC <= rob_flush_pc.
REQ-027 Flush in IDLE -> IDLE, no request that cycle; flush in WAIT with ic_rsp_valid -> IDLE (response dropped); flush in WAIT without response -> DISCARD.
REQ-028 DISCARD: no request, no push; ic_rsp_valid -> IDLE; further flush updates PC, stays DISCARD (or IDLE if response same cycle).
REQ-029 rdy low: no state, PC, or queue change; ic_req_valid = 0; iq_pop, ic_rsp_valid, rob_flush ignored.
REQ-030 iq_* outputs combinational from head entry; iq_instr/iq_pc/iq_pred_pc are don't-care when iq_valid = 0.

Reset
REQ-031 On reset: PC = RESET_PC, state IDLE, head = tail = count = 0; overrides rdy and all inputs.
REQ-032 During reset cycle ic_req_valid = 0, iq_valid = 0; first request in the cycle after reset deasserts, with ic_req_pc = RESET_PC.
REQ-033 Queue storage needs no reset.

Structure
REQ-034 Data-width range macro and RESET_PC default SHALL live in the shared const header; FSM encodings local.
REQ-035 Queue SHALL be sub-module instr_queue (push/pop/flush, full/empty, head data); FSM and PC in instr_fetcher.

Verification
REQ-036 Reset then ICache 1-cycle latency, predictor returns pc+4 -> requests at 0x0, 0x4, 0x8 every 2 cycles; queue entries {0x0, instr, 0x4}, ...
REQ-037 No pops, IQ_DEPTH=16 -> exactly 16 pushes, ic_req_valid stays 0 while count=16; one pop -> one new request next cycle.
REQ-038 rob_flush with rob_flush_pc=0x100 while WAIT, response 2 cycles later -> response dropped, count 0, next request 0x100.
REQ-039 Push+pop same cycle at count=16 from wrap (head=15, tail=15) -> count stays, pointers wrap to 0, FIFO order preserved.
REQ-040 rdy low for 5 cycles with ic_rsp_valid, iq_pop, rob_flush pulsed -> no state/queue change, ic_req_valid 0.
